// File: rtl/hs_src_arbiter.sv
// hs_src_arbiter: round-robin arbiter sharing one two-phase handshake CDC
// channel among 2**IDW requesters in the source (sclk) domain.
// Optional macro HS_ARB_TIMEOUT_EN: WAIT-state timeout with sticky tmo_err.
module hs_src_arbiter #(
   parameter int unsigned IDW     = 2,
   parameter int unsigned WIDTH   = 30,
   parameter int unsigned TMO_CYC = 1023
) (
   input  logic                          sclk,
   input  logic                          rst_n,
   input  logic [2**IDW-1:0]             req,
   input  logic [(2**IDW)*WIDTH-1:0]     req_data,
   output logic [2**IDW-1:0]             grant,
   input  logic                          sidle,
   output logic                          sready,
   output logic [WIDTH+IDW-1:0]          hs_din,
   output logic                          busy,
   output logic [15:0]                   xfer_cnt,
   input  logic                          err_clr,
   output logic                          tmo_err
);

   localparam int unsigned NREQ = 2**IDW;
   localparam int unsigned DW   = WIDTH + IDW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t            state_q;
   logic [IDW-1:0]    ptr_q;
   logic [NREQ-1:0]   grant_q;
   logic              sready_q;
   logic [DW-1:0]     hs_din_q;
   logic              busy_q;
   logic [15:0]       xfer_cnt_q;

   logic [IDW-1:0]    win_c;
   logic [IDW-1:0]    idx_c;
   logic              found_c;
   logic [WIDTH-1:0]  pay_c;

`ifdef HS_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = 10;
   logic [CNT_W-1:0]  tmo_cnt_q;
   logic              tmo_err_q;
`endif

   // Round-robin search: first set request strictly after the last winner, with wrap
   always_comb begin
      win_c   = ptr_q;
      idx_c   = ptr_q;
      found_c = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx_c = ptr_q + IDW'(i);
         if (!found_c && req[idx_c]) begin
            win_c   = idx_c;
            found_c = 1'b1;
         end
      end
   end

   // Payload mux for the current winner
   always_comb begin
      pay_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_c == IDW'(i)) begin
            pay_c = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Arbitration FSM with registered grant/sready/hs_din/busy/counters
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= IDW'(NREQ - 1);
         grant_q    <= '0;
         sready_q   <= 1'b0;
         hs_din_q   <= '0;
         busy_q     <= 1'b0;
         xfer_cnt_q <= '0;
`ifdef HS_ARB_TIMEOUT_EN
         tmo_cnt_q  <= '0;
         tmo_err_q  <= 1'b0;
`endif
      end else begin
         sready_q <= 1'b0;
         grant_q  <= '0;
`ifdef HS_ARB_TIMEOUT_EN
         // Clear first so a timeout set later in this block takes priority
         if (err_clr) begin
            tmo_err_q <= 1'b0;
         end
`endif
         case (state_q)
            IDLE: begin
               if (sidle && found_c) begin
                  hs_din_q <= {win_c, pay_c};
                  ptr_q    <= win_c;
                  sready_q <= 1'b1;
                  grant_q  <= NREQ'(1) << win_c;
                  busy_q   <= 1'b1;
                  state_q  <= SEND;
               end
            end
            SEND: begin
               xfer_cnt_q <= xfer_cnt_q + 16'd1;
               state_q    <= WAIT;
`ifdef HS_ARB_TIMEOUT_EN
               tmo_cnt_q  <= '0;
`endif
            end
            WAIT: begin
               if (sidle) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
`ifdef HS_ARB_TIMEOUT_EN
               else if (tmo_cnt_q == CNT_W'(TMO_CYC - 1)) begin
                  tmo_err_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end
`endif
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant    = grant_q;
   assign sready   = sready_q;
   assign hs_din   = hs_din_q;
   assign busy     = busy_q;
   assign xfer_cnt = xfer_cnt_q;

`ifdef HS_ARB_TIMEOUT_EN
   assign tmo_err  = tmo_err_q;
`else
   // Without the timeout there is no error source; err_clr has no effect
   logic unused_c;
   assign unused_c = err_clr ^ (TMO_CYC != 0);
   assign tmo_err  = 1'b0;
`endif

endmodule

// File: tb/tb_hs_src_arbiter.sv
// Bench for hs_src_arbiter: directed vector table, hand sequences and a
// randomized run against a round-robin reference model.
module tb_hs_src_arbiter;

   localparam int unsigned IDW   = 2;
   localparam int unsigned WIDTH = 30;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned DW    = WIDTH + IDW;
`ifdef HS_ARB_TIMEOUT_EN
   localparam int unsigned TMO   = 16;
`else
   localparam int unsigned TMO   = 1023;
`endif

   logic                    sclk = 1'b0;
   logic                    rst_n;
   logic [NREQ-1:0]         req;
   logic [NREQ*WIDTH-1:0]   req_data;
   logic [NREQ-1:0]         grant;
   logic                    sidle;
   logic                    sready;
   logic [DW-1:0]           hs_din;
   logic                    busy;
   logic [15:0]             xfer_cnt;
   logic                    err_clr;
   logic                    tmo_err;

   logic [WIDTH-1:0]        pay [NREQ];
   logic                    sidle_smp;

   int n_cmp = 0;
   int n_err = 0;
   int last_w;
   int xfer_exp;

   typedef struct {
      logic [NREQ-1:0] m;
      int              exp_w;
   } vec_t;
   vec_t tbl [12];

   hs_src_arbiter #(.IDW(IDW), .WIDTH(WIDTH), .TMO_CYC(TMO)) dut (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .grant    (grant),
      .sidle    (sidle),
      .sready   (sready),
      .hs_din   (hs_din),
      .busy     (busy),
      .xfer_cnt (xfer_cnt),
      .err_clr  (err_clr),
      .tmo_err  (tmo_err)
   );

   always #5 sclk = ~sclk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = pay[i];
   end

   always @(posedge sclk) sidle_smp <= sidle;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: requester with the smallest rotational distance after the last winner
   function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
      int best = -1;
      int bestd = NREQ + 1;
      for (int i = 0; i < NREQ; i++) begin
         int d = (i - last + NREQ - 1) % NREQ;
         if (m[i] && d < bestd) begin
            best  = i;
            bestd = d;
         end
      end
      return best;
   endfunction

   task automatic check_reset(input string nm);
      chk({nm, "_sready"},   64'(sready),   64'd0);
      chk({nm, "_grant"},    64'(grant),    64'd0);
      chk({nm, "_hs_din"},   64'(hs_din),   64'd0);
      chk({nm, "_busy"},     64'(busy),     64'd0);
      chk({nm, "_xfer_cnt"}, 64'(xfer_cnt), 64'd0);
      chk({nm, "_tmo_err"},  64'(tmo_err),  64'd0);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      req     = '0;
      sidle   = 1'b1;
      err_clr = 1'b0;
      repeat (2) @(negedge sclk);
      rst_n    = 1'b1;
      last_w   = NREQ - 1;
      xfer_exp = 0;
      @(negedge sclk);
   endtask

   // Wait (bounded) for an sready pulse; cyc = negedges taken, -1 on timeout
   task automatic wait_sready(input int maxc, output int cyc);
      cyc = -1;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge sclk);
         if (sready) begin
            cyc = i;
            chk("sidle_at_launch", 64'(sidle_smp), 64'd1);
            break;
         end
      end
      if (cyc < 0) chk("sready_timeout", 64'd0, 64'd1);
   endtask

   task automatic check_grant(input string nm, input int w);
      logic [NREQ-1:0] g;
      logic [DW-1:0]   d;
      g = NREQ'(1) << w;
      d = {IDW'(w), pay[w]};
      chk({nm, "_grant"},  64'(grant),  64'(g));
      chk({nm, "_hs_din"}, 64'(hs_din), 64'(d));
      chk({nm, "_busy"},   64'(busy),   64'd1);
   endtask

   // One complete transfer from IDLE; requester drops req in its grant cycle
   task automatic do_xfer(input logic [NREQ-1:0] m, input int exp_w, input int dly, input string nm);
      int cyc;
      req = m;
      wait_sready(8, cyc);
      if (cyc > 0) begin
         check_grant(nm, exp_w);
         last_w = exp_w;
         xfer_exp++;
      end
      req   = '0;
      sidle = 1'b0;
      repeat (dly) @(negedge sclk);
      sidle = 1'b1;
      @(negedge sclk);
      chk({nm, "_idle_busy"}, 64'(busy),     64'd0);
      chk({nm, "_xfer_cnt"},  64'(xfer_cnt), 64'(16'(xfer_exp)));
   endtask

   initial begin
      int cyc;
      int hits;
      logic [NREQ-1:0] m;
      int w;

      tbl[0]  = '{4'b0001, 0};
      tbl[1]  = '{4'b1111, 1};
      tbl[2]  = '{4'b1111, 2};
      tbl[3]  = '{4'b1111, 3};
      tbl[4]  = '{4'b1111, 0};
      tbl[5]  = '{4'b0100, 2};
      tbl[6]  = '{4'b0110, 1};
      tbl[7]  = '{4'b0110, 2};
      tbl[8]  = '{4'b1001, 3};
      tbl[9]  = '{4'b1001, 0};
      tbl[10] = '{4'b1000, 3};
      tbl[11] = '{4'b0011, 0};

      pay[0] = 30'h1234567;
      pay[1] = 30'h2BCDEF0;
      pay[2] = 30'h3A5A5A5;
      pay[3] = 30'h0F0F0F0;

      // Reset values
      rst_n = 1'b0; req = '0; sidle = 1'b1; err_clr = 1'b0;
      #12;
      check_reset("reset");
      do_reset();

      // First transfer: exact latency and payload
      req = 4'b0001;
      wait_sready(8, cyc);
      chk("first_latency", 64'(cyc), 64'd1);
      chk("first_grant", 64'(grant), 64'h1);
      chk("first_hs_din", 64'(hs_din), 64'h01234567);
      req = '0; sidle = 1'b0;
      @(negedge sclk);
      chk("first_xfer_cnt", 64'(xfer_cnt), 64'd1);
      chk("first_wait_busy", 64'(busy), 64'd1);
      repeat (2) @(negedge sclk);
      sidle = 1'b1;
      @(negedge sclk);

      // All requesting, held: order 0,1,2,3,0 and 2-cycle re-issue after sidle rise
      do_reset();
      req = 4'b1111;
      wait_sready(8, cyc);
      for (int k = 0; k < 5; k++) begin
         check_grant("held", k % NREQ);
         sidle = 1'b0;
         if (k == 4) req = '0;
         hits = 0;
         for (int j = 0; j < 4; j++) begin
            @(negedge sclk);
            if (sready) hits++;
         end
         chk("held_no_sready_busy", 64'(hits), 64'd0);
         sidle = 1'b1;
         if (k < 4) begin
            wait_sready(8, cyc);
            chk("held_reissue_latency", 64'(cyc), 64'd2);
         end
      end
      @(negedge sclk);
      chk("held_xfer_cnt", 64'(xfer_cnt), 64'd5);

      // Vector table from a fresh reset
      do_reset();
      for (int i = 0; i < 12; i++) begin
         do_xfer(tbl[i].m, tbl[i].exp_w, 1 + (i % 3), $sformatf("vec%0d", i));
      end

      // Channel busy in IDLE: no arbitration while sidle is low
      sidle = 1'b0;
      req   = 4'b0001;
      hits  = 0;
      for (int j = 0; j < 50; j++) begin
         @(negedge sclk);
         if (sready || grant != '0) hits++;
      end
      chk("stall_no_launch", 64'(hits), 64'd0);
      chk("stall_tmo_err", 64'(tmo_err), 64'd0);
      sidle = 1'b1;
      wait_sready(8, cyc);
      chk("stall_release_latency", 64'(cyc), 64'd1);
      w = rr_pick(4'b0001, last_w);
      check_grant("stall", w);
      last_w = w; xfer_exp++;
      req = '0; sidle = 1'b0;
      repeat (2) @(negedge sclk);
      sidle = 1'b1;
      @(negedge sclk);

      // Randomized transfers against the reference model
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < NREQ; j++) pay[j] = WIDTH'($urandom);
         m = NREQ'($urandom_range(1, 15));
         w = rr_pick(m, last_w);
         do_xfer(m, w, int'($urandom_range(1, 6)), "rnd");
      end

`ifdef HS_ARB_TIMEOUT_EN
      // Hung channel: timeout after TMO WAIT cycles, then clear
      req = 4'b0100;
      wait_sready(8, cyc);
      w = rr_pick(4'b0100, last_w);
      check_grant("tmo", w);
      last_w = w; xfer_exp++;
      req = '0; sidle = 1'b0;
      repeat (TMO) @(negedge sclk);
      chk("tmo_not_yet", 64'(tmo_err), 64'd0);
      chk("tmo_not_yet_busy", 64'(busy), 64'd1);
      @(negedge sclk);
      chk("tmo_set", 64'(tmo_err), 64'd1);
      chk("tmo_busy", 64'(busy), 64'd0);
      err_clr = 1'b1;
      @(negedge sclk);
      err_clr = 1'b0;
      chk("tmo_cleared", 64'(tmo_err), 64'd0);
      sidle = 1'b1;
      @(negedge sclk);
`endif

      // Reset in the middle of WAIT with five words launched
      do_reset();
      for (int i = 0; i < 4; i++) begin
         m = NREQ'($urandom_range(1, 15));
         do_xfer(m, rr_pick(m, last_w), 2, "pre_rst");
      end
      req = 4'b0010;
      wait_sready(8, cyc);
      req = '0; sidle = 1'b0;
      @(negedge sclk);
      chk("mid_xfer_cnt", 64'(xfer_cnt), 64'd5);
      chk("mid_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_reset("mid_reset");
      @(negedge sclk);
      rst_n = 1'b1; sidle = 1'b1;
      req = 4'b1000;
      wait_sready(8, cyc);
      chk("post_rst_latency", 64'(cyc), 64'd1);
      check_grant("post_rst", 3);
      req = '0; sidle = 1'b0;
      repeat (2) @(negedge sclk);
      sidle = 1'b1;
      @(negedge sclk);
      chk("post_rst_xfer_cnt", 64'(xfer_cnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
